// File: rtl/cr16_seg_display_ctrl.sv
// N-digit seven-segment driver: renders one written word as hex or unsigned decimal.
// Define CR16_SEG_DISPLAY_LZB_EN to blank leading zero digits.
module cr16_seg_display_ctrl #(
  parameter int unsigned P_NUM_DIGITS = 6,
  parameter int unsigned P_DATA_WIDTH = 16
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic                    I_WRITE_EN,
  input  logic [P_DATA_WIDTH-1:0] I_WRITE_DATA,
  input  logic                    I_DECIMAL_MODE,
  output logic [6:0]              O_7_SEGMENT_DISPLAY [P_NUM_DIGITS],
  output logic                    O_BUSY,
  output logic                    O_DONE,
  output logic                    O_OVERFLOW
);

  localparam int unsigned BcdW    = 4 * P_NUM_DIGITS;
  localparam int unsigned ExtW    = (BcdW > P_DATA_WIDTH) ? BcdW : P_DATA_WIDTH;
  localparam int unsigned CntW    = $clog2(P_DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(P_DATA_WIDTH - 1);
  localparam logic [6:0] GlyphBlank = 7'h7F;
  localparam logic [6:0] GlyphDash  = 7'h3F;

  typedef enum logic [1:0] {StIdle, StConvert, StLoad} state_e;

  state_e                  state_q;
  logic [P_DATA_WIDTH-1:0] data_q;
  logic                    dec_q;
  logic [BcdW-1:0]         bcd_q;
  logic [CntW-1:0]         cnt_q;
  logic                    ovf_sticky_q;
  logic [6:0]              seg_q [P_NUM_DIGITS];
  logic                    busy_q;
  logic                    done_q;
  logic                    ovf_q;

  logic [BcdW-1:0]         bcd_adj;
  logic [BcdW-1:0]         bcd_step;
  logic [ExtW-1:0]         data_ext;
  logic                    hex_ovf;
  logic [BcdW-1:0]         load_nibs;
  logic                    load_ovf;
  logic [6:0]              load_seg [P_NUM_DIGITS];
`ifdef CR16_SEG_DISPLAY_LZB_EN
  logic                    lead;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    seg = GlyphBlank;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // One double-dabble step: add-3 correction, then shift the next value bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < P_NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = {bcd_adj[BcdW-2:0], data_q[P_DATA_WIDTH-1]};
  end

  always_comb begin
    data_ext  = ExtW'(data_q);
    hex_ovf   = |(data_ext >> BcdW);
    load_nibs = dec_q ? bcd_q : data_ext[BcdW-1:0];
    load_ovf  = dec_q ? ovf_sticky_q : hex_ovf;
  end

  always_comb begin
    for (int i = 0; i < P_NUM_DIGITS; i++) begin
      load_seg[i] = load_ovf ? GlyphDash : glyph(load_nibs[4*i +: 4]);
    end
`ifdef CR16_SEG_DISPLAY_LZB_EN
    lead = 1'b1;
    if (!load_ovf) begin
      // Digit 0 is excluded so a zero value still shows one '0'.
      for (int i = P_NUM_DIGITS - 1; i > 0; i--) begin
        if (load_nibs[4*i +: 4] != 4'd0) lead = 1'b0;
        if (lead) load_seg[i] = GlyphBlank;
      end
    end
`endif
  end

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state_q      <= StIdle;
      data_q       <= '0;
      dec_q        <= 1'b0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < P_NUM_DIGITS; i++) seg_q[i] <= GlyphBlank;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (I_WRITE_EN) begin
            data_q <= I_WRITE_DATA;
            dec_q  <= I_DECIMAL_MODE;
            if (I_DECIMAL_MODE) begin
              bcd_q        <= '0;
              cnt_q        <= '0;
              ovf_sticky_q <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= StConvert;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StConvert: begin
          bcd_q        <= bcd_step;
          data_q       <= data_q << 1;
          ovf_sticky_q <= ovf_sticky_q | bcd_adj[BcdW-1];
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            busy_q  <= 1'b0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          for (int i = 0; i < P_NUM_DIGITS; i++) seg_q[i] <= load_seg[i];
          done_q  <= 1'b1;
          ovf_q   <= load_ovf;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign O_7_SEGMENT_DISPLAY = seg_q;
  assign O_BUSY              = busy_q;
  assign O_DONE              = done_q;
  assign O_OVERFLOW          = ovf_q;

endmodule

// File: tb/tb_cr16_seg_display_ctrl.sv
// Randomised bench for cr16_seg_display_ctrl: a 6-digit and a 4-digit instance against
// a radix-arithmetic reference model.
module tb_cr16_seg_display_ctrl;

  localparam logic [6:0] Glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [55:0] AllBlank = {8{7'h7F}};

  logic        clk;
  logic        rst_n;
  logic        we6, dm6, we4, dm4;
  logic [15:0] wd6, wd4;
  logic [6:0]  seg6 [6];
  logic [6:0]  seg4 [4];
  logic        busy6, done6, ovf6, busy4, done4, ovf4;

  int          n_checks;
  int          n_errors;
  logic [55:0] exp_seg6, exp_seg4;
  logic        exp_ovf6, exp_ovf4;

  cr16_seg_display_ctrl #(.P_NUM_DIGITS(6), .P_DATA_WIDTH(16)) dut6 (
    .I_CLK               (clk),
    .I_NRESET            (rst_n),
    .I_WRITE_EN          (we6),
    .I_WRITE_DATA        (wd6),
    .I_DECIMAL_MODE      (dm6),
    .O_7_SEGMENT_DISPLAY (seg6),
    .O_BUSY              (busy6),
    .O_DONE              (done6),
    .O_OVERFLOW          (ovf6)
  );

  cr16_seg_display_ctrl #(.P_NUM_DIGITS(4), .P_DATA_WIDTH(16)) dut4 (
    .I_CLK               (clk),
    .I_NRESET            (rst_n),
    .I_WRITE_EN          (we4),
    .I_WRITE_DATA        (wd4),
    .I_DECIMAL_MODE      (dm4),
    .O_7_SEGMENT_DISPLAY (seg4),
    .O_BUSY              (busy4),
    .O_DONE              (done4),
    .O_OVERFLOW          (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned radix_limit(input int unsigned n, input bit dec);
    int unsigned lim = 1;
    for (int i = 0; i < int'(n); i++) lim = lim * (dec ? 10 : 16);
    return lim;
  endfunction

  function automatic logic [55:0] model_segs(input int unsigned n, input int unsigned v,
                                             input bit dec);
    logic [55:0] r = AllBlank;
    int unsigned base = dec ? 10 : 16;
    int unsigned w = v;
    int unsigned d;
    int top = 0;
    if (v >= radix_limit(n, dec)) begin
      for (int i = 0; i < int'(n); i++) r[7*i +: 7] = 7'h3F;
      return r;
    end
    for (int i = 0; i < int'(n); i++) begin
      d = w % base;
      w = w / base;
      r[7*i +: 7] = Glyph[d];
      if (d != 0) top = i;
    end
`ifdef CR16_SEG_DISPLAY_LZB_EN
    for (int i = top + 1; i < int'(n); i++) r[7*i +: 7] = 7'h7F;
`endif
    return r;
  endfunction

  function automatic logic seg_busy(input bit sel);
    return sel ? busy4 : busy6;
  endfunction

  function automatic logic seg_done(input bit sel);
    return sel ? done4 : done6;
  endfunction

  function automatic logic [6:0] seg_of(input bit sel, input int i);
    return sel ? seg4[i] : seg6[i];
  endfunction

  task automatic check_display(input bit sel, input string tag);
    int n = sel ? 4 : 6;
    logic [55:0] e = sel ? exp_seg4 : exp_seg6;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_seg%0d", tag, i), {25'd0, seg_of(sel, i)}, {25'd0, e[7*i +: 7]});
    end
    check_eq({tag, "_ovf"}, {31'd0, sel ? ovf4 : ovf6}, {31'd0, sel ? exp_ovf4 : exp_ovf6});
  endtask

  // Wait for O_DONE after the accepting edge; sample 0 is the negedge just after that edge.
  task automatic await_done(input bit sel, input bit dec, input string tag);
    int  busy_cnt = 0;
    int  lat = 0;
    bit  seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (seg_busy(sel)) busy_cnt++;
      @(negedge clk);
      if (seg_done(sel)) begin
        seen = 1;
        lat  = c;
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_latency"}, lat, dec ? 32'd17 : 32'd1);
    check_eq({tag, "_busy_cycles"}, busy_cnt, dec ? 32'd16 : 32'd0);
    if (seen) begin
      check_display(sel, tag);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, {31'd0, seg_done(sel)}, 32'd0);
    end
  endtask

  task automatic run_write(input bit sel, input int unsigned v, input bit dec, input string tag);
    @(negedge clk);
    if (sel) begin
      we4 = 1'b1; wd4 = 16'(v); dm4 = dec;
    end else begin
      we6 = 1'b1; wd6 = 16'(v); dm6 = dec;
    end
    @(negedge clk);
    we4 = 1'b0;
    we6 = 1'b0;
    dm4 = 1'($urandom);
    dm6 = 1'($urandom);
    if (sel) begin
      exp_seg4 = model_segs(4, v & 32'hFFFF, dec);
      exp_ovf4 = (v & 32'hFFFF) >= radix_limit(4, dec);
    end else begin
      exp_seg6 = model_segs(6, v & 32'hFFFF, dec);
      exp_ovf6 = (v & 32'hFFFF) >= radix_limit(6, dec);
    end
    await_done(sel, dec, tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned v;
    bit          sel, dec;
    int          done_hits;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    we6 = 1'b0; dm6 = 1'b0; wd6 = '0;
    we4 = 1'b0; dm4 = 1'b0; wd4 = '0;
    exp_seg6 = AllBlank; exp_seg4 = AllBlank;
    exp_ovf6 = 1'b0;     exp_ovf4 = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_display(1'b0, "reset6");
    check_display(1'b1, "reset4");
    check_eq("reset_busy", {31'd0, busy6}, 32'd0);
    check_eq("reset_done", {31'd0, done6}, 32'd0);

    run_write(1'b0, 32'hBEEF, 1'b0, "hex_beef");
    run_write(1'b0, 32'd65535, 1'b1, "dec_65535");
    run_write(1'b0, 32'd42, 1'b1, "dec_42");
    run_write(1'b0, 32'h0000, 1'b0, "hex_0");
    run_write(1'b1, 32'd9999, 1'b1, "n4_dec_9999");
    run_write(1'b1, 32'd10000, 1'b1, "n4_dec_10000");
    run_write(1'b1, 32'hFFFF, 1'b0, "n4_hex_ffff");

    // A write while busy is dropped; the pending conversion finishes untouched.
    @(negedge clk);
    we6 = 1'b1; wd6 = 16'd1234; dm6 = 1'b1;
    @(negedge clk);
    we6 = 1'b0;
    exp_seg6 = model_segs(6, 1234, 1'b1);
    exp_ovf6 = 1'b0;
    @(negedge clk);
    we6 = 1'b1; wd6 = 16'hFFFF; dm6 = 1'b0;
    @(negedge clk);
    we6 = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("drop_done_early", {31'd0, done6}, 32'd0);
    @(negedge clk);
    check_eq("drop_done", {31'd0, done6}, 32'd1);
    check_display(1'b0, "drop");
    repeat (5) @(negedge clk);
    check_display(1'b0, "hold");

    // Reset mid-conversion aborts and blanks.
    @(negedge clk);
    we6 = 1'b1; wd6 = 16'd1234; dm6 = 1'b1;
    @(negedge clk);
    we6 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_seg6 = AllBlank; exp_seg4 = AllBlank;
    exp_ovf6 = 1'b0;     exp_ovf4 = 1'b0;
    check_display(1'b0, "abort");
    check_eq("abort_busy", {31'd0, busy6}, 32'd0);
    done_hits = 0;
    for (int c = 0; c < 25; c++) begin
      if (done6) done_hits++;
      @(negedge clk);
    end
    check_eq("abort_no_done", done_hits, 32'd0);
    check_display(1'b1, "abort4");

    for (int k = 0; k < 30; k++) begin
      sel = 1'($urandom);
      dec = 1'($urandom);
      if (sel && dec && $urandom_range(0, 1) == 1) v = $urandom_range(9990, 10010);
      else v = $urandom_range(0, 65535);
      run_write(sel, v, dec, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cr16_seg_display_ctrl.md
# cr16_seg_display_ctrl

Parametrised seven-segment display controller for the CR16 top level. It replaces the fixed six-digit hex display path with a configurable N-digit driver that the CPU or top-level glue writes one word into. It renders the word as hexadecimal or as unsigned decimal, using a sequential double-dabble converter, and drives registered segment patterns onto the board display.

## Interface

Parameters:
- P_NUM_DIGITS, 6, number of seven-segment digits driven (1–8).
- P_DATA_WIDTH, 16, width of the written value (4–32).

Ports:
- I_CLK, input, 1, system clock.
- I_NRESET, input, 1, reset: one clock, synchronous, active-low; sampled on the rising edge of I_CLK.
- I_WRITE_EN, input, 1, write strobe; accepted only when O_BUSY=0.
- I_WRITE_DATA, input, P_DATA_WIDTH, value to display.
- I_DECIMAL_MODE, input, 1, 0 selects hex rendering, 1 selects unsigned decimal; sampled with the write.
- O_7_SEGMENT_DISPLAY, output, [6:0] x P_NUM_DIGITS, unpacked array. Index 0 is the rightmost digit. Bit order is gfedcba, active-low.
- O_BUSY, output, 1, decimal conversion in progress.
- O_DONE, output, 1, one-cycle pulse when the display registers update.
- O_OVERFLOW, output, 1, the last accepted value did not fit in P_NUM_DIGITS digits.

## Operation

- Reset (I_NRESET=0 at an edge):
  - every digit is 7'h7F (blank);
  - O_BUSY=0, O_DONE=0, O_OVERFLOW=0;
  - FSM goes to IDLE.
  - Reset overrides all other activity, including a conversion in progress (aborted, result discarded).
- FSM states: IDLE, CONVERT, LOAD.
- IDLE:
  - I_WRITE_EN=1 captures I_WRITE_DATA and I_DECIMAL_MODE.
  - Hex mode: go to LOAD.
  - Decimal mode: clear the BCD register (4·P_NUM_DIGITS bits) and the bit counter, then go to CONVERT.
- CONVERT:
  - One double-dabble iteration per cycle: add 3 to every BCD nibble ≥5, then shift the value MSB into the BCD LSB.
  - A 1 shifted out of the BCD MSB sets a sticky overflow flag.
  - After exactly P_DATA_WIDTH iterations, go to LOAD.
- LOAD:
  - Load the digit registers, pulse O_DONE, update O_OVERFLOW, return to IDLE.
- Hex rendering:
  - Digit i shows nibble i of the value; digits beyond the value width show 0.
  - Overflow when any bit at or above bit 4·P_NUM_DIGITS is nonzero.
- Overflow display: all digits show '-' (7'h3F) and O_OVERFLOW=1. Otherwise O_OVERFLOW=0.
- Glyph encoding (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78;
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Writes with O_BUSY=1 are ignored and dropped. The current conversion is unaffected.
- The display holds its last value indefinitely between writes.

## Timing

Write accepted at edge t:
- Hex mode:
  - state=LOAD after edge t;
  - digits, O_OVERFLOW and O_DONE=1 valid after edge t+1;
  - O_BUSY stays 0 throughout.
- Decimal mode:
  - O_BUSY=1 after edge t;
  - CONVERT occupies edges t+1..t+P_DATA_WIDTH;
  - after edge t+P_DATA_WIDTH+1: digits, O_OVERFLOW and O_DONE=1 are valid and O_BUSY=0.
  - Total latency is P_DATA_WIDTH+1 cycles.
- O_DONE is high for exactly one cycle.
- A new write is accepted in the cycle O_DONE is high.
- I_DECIMAL_MODE changing while O_BUSY=1 has no effect.

## Configuration

- Macro: CR16_SEG_DISPLAY_LZB_EN, leading-zero blanking.
- Defined:
  - after a non-overflow LOAD, every digit above the most significant nonzero digit shows blank (7'h7F);
  - digit 0 is never blanked, so the value 0 shows a single '0'.
- Undefined: all P_NUM_DIGITS digits are always shown, including leading zeros.
- Timing and overflow behaviour are identical in both builds.

## Test plan

- Reset with I_NRESET=0 for 2 cycles, then release → all digits 7'h7F; O_BUSY=0, O_DONE=0, O_OVERFLOW=0.
- Defaults, hex write 16'hBEEF, macro undefined:
  - one cycle later digits[3:0] = 03,06,06,0E and digits[5:4] = 40;
  - O_DONE pulses once; O_BUSY never rises.
- Defaults, decimal write 16'd65535:
  - O_BUSY high for 16 cycles;
  - at cycle 17 digits[5:0] = 40,02,12,12,30,12 and O_DONE=1.
- P_NUM_DIGITS=4:
  - decimal 16'd9999 → all digits 7'h10, O_OVERFLOW=0;
  - decimal 16'd10000 → all digits 7'h3F, O_OVERFLOW=1.
- Busy and reset behaviour:
  - write decimal 16'd1234, then write 16'hFFFF two cycles later → second write dropped; result shows 001234;
  - repeat with I_NRESET=0 pulsed mid-conversion → display blank, O_BUSY=0, no O_DONE.
- Macro defined:
  - decimal 16'd42 → digits[5:2]=7F, digits[1:0]=19,24;
  - hex 16'h0000 → digits[5:1]=7F, digit[0]=40.
